serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 120 ++++++++++++
 tb/tb_serial_adder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Purpose: bit-serial WIDTH-bit adder, one full-add step per clock, LSB first.
// Latency: accept on edge E0, result valid after edge E0+WIDTH; at most one result per WIDTH+2 cycles.
// Backpressure: in_ready low outside IDLE; result held in DONE until out_ready.
//
// Ports:
//   clk, rst_n           clock (rising edge) and asynchronous active-low reset
//   in_valid/in_ready    operand handshake; a and b are sampled only on the accept edge
//   a, b                 WIDTH-bit addends
//   out_valid/out_ready  result handshake
//   sum, cout            registered (a+b) mod 2^WIDTH and carry-out bit WIDTH of a+b
module serial_adder #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   sh_a_q;
    logic [WIDTH-1:0]   sh_b_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               in_ready_q;
    logic               out_valid_q;

    // Full-add step on the current LSBs: half-adder pair plus the carry flop.
    logic               half_s;
    logic               s_bit;
    logic               carry_d;
    logic               last_bit;
    logic [CNT_W-1:0]   cnt_d;

    always_comb begin
        half_s   = sh_a_q[0] ^ sh_b_q[0];
        s_bit    = half_s ^ carry_q;
        carry_d  = (sh_a_q[0] & sh_b_q[0]) | (half_s & carry_q);
        last_bit = (cnt_q == CNT_W'(WIDTH - 1));
        cnt_d    = cnt_q + CNT_W'(1);
    end

    // Handshake flags are registered alongside the state so they are pure
    // flop outputs: in_ready mirrors IDLE, out_valid mirrors DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sh_a_q      <= '0;
            sh_b_q      <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        sh_a_q     <= a;
                        sh_b_q     <= b;
                        sum_q      <= '0;
                        cout_q     <= 1'b0;
                        carry_q    <= 1'b0;
                        cnt_q      <= '0;
                        state_q    <= RUN;
                        in_ready_q <= 1'b0;
                    end
                end
                RUN: begin
                    // Sum fills from the MSB end, so after WIDTH shifts bit 0
                    // of the result sits in sum_q[0].
                    sum_q   <= {s_bit, sum_q[WIDTH-1:1]};
                    sh_a_q  <= {1'b0, sh_a_q[WIDTH-1:1]};
                    sh_b_q  <= {1'b0, sh_b_q[WIDTH-1:1]};
                    carry_q <= carry_d;
                    cnt_q   <= cnt_d;
                    if (last_bit) begin
                        cout_q      <= carry_d;
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Purpose: self-checking bench for serial_adder (table vectors, corner sequences, random traffic).
// Latency: checks exact WIDTH-cycle accept-to-valid latency.
// Backpressure: exercises out_ready stalls and in_valid held during RUN/DONE.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_out  = 0;

    logic [W:0] sb[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Inputs change 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: handshakes are observed on the falling edge, mid-cycle,
    // and take effect on the following rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready)
                sb.push_back({1'b0, a} + {1'b0, b});
            if (out_valid && out_ready) begin
                n_out++;
                if (sb.size() == 0) begin
                    chk("sb_unexpected_output", {23'd0, cout, sum}, 32'hFFFF_FFFF);
                end else begin
                    logic [W:0] e;
                    e = sb.pop_front();
                    chk("sb_result", {23'd0, cout, sum}, {23'd0, e});
                end
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            step();
            n++;
        end
        if (!in_ready) chk("timeout_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        while (!out_valid && n < 200) begin
            step();
            n++;
        end
        if (!out_valid) chk("timeout_out_valid", 32'(out_valid), 32'd1);
    endtask

    // One-cycle in_valid pulse once the block is idle.
    task automatic issue(input logic [W-1:0] va, input logic [W-1:0] vb);
        wait_ready();
        a        = va;
        b        = vb;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] sum;
        logic         cout;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int base;
        vecs[0] = '{a: 8'd250, b: 8'd7,   sum: 8'd1,   cout: 1'b1};
        vecs[1] = '{a: 8'd255, b: 8'd1,   sum: 8'd0,   cout: 1'b1};
        vecs[2] = '{a: 8'd0,   b: 8'd0,   sum: 8'd0,   cout: 1'b0};
        vecs[3] = '{a: 8'd128, b: 8'd128, sum: 8'd0,   cout: 1'b1};
        vecs[4] = '{a: 8'd85,  b: 8'd170, sum: 8'd255, cout: 1'b0};
        vecs[5] = '{a: 8'd255, b: 8'd255, sum: 8'd254, cout: 1'b1};

        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        rst_n     = 1'b0;
        #23;
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum",       32'(sum),       32'd0);
        chk("rst_cout",      32'(cout),      32'd0);
        rst_n = 1'b1;
        step();

        // 1: 5+6, exact latency and one-cycle output handshake.
        a = 8'd5; b = 8'd6; in_valid = 1'b1;
        step();                         // accept edge E0
        in_valid = 1'b0;
        chk("t1_in_ready_drop", 32'(in_ready), 32'd0);
        for (int i = 1; i < W; i++) begin
            step();
            chk("t1_latency_low", 32'(out_valid), 32'd0);
        end
        step();                         // E0+8
        chk("t1_out_valid", 32'(out_valid), 32'd1);
        chk("t1_sum",  32'(sum),  32'd11);
        chk("t1_cout", 32'(cout), 32'd0);
        step();
        chk("t1_out_valid_one_cycle", 32'(out_valid), 32'd0);
        chk("t1_in_ready_back",       32'(in_ready),  32'd1);

        // 2: table vectors.
        for (int i = 0; i < 6; i++) begin
            issue(vecs[i].a, vecs[i].b);
            wait_out();
            chk("vec_sum",  32'(sum),  32'(vecs[i].sum));
            chk("vec_cout", 32'(cout), 32'(vecs[i].cout));
            step();
        end

        // 3: backpressure holds the result.
        out_ready = 1'b0;
        issue(8'd150, 8'd2);
        wait_out();
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t3_hold_valid", 32'(out_valid), 32'd1);
            chk("t3_hold_ready", 32'(in_ready),  32'd0);
            chk("t3_hold_sum",   32'(sum),       32'd152);
            chk("t3_hold_cout",  32'(cout),      32'd0);
        end
        out_ready = 1'b1;
        step();
        chk("t3_release_valid", 32'(out_valid), 32'd0);
        chk("t3_release_ready", 32'(in_ready),  32'd1);

        // 4: new operands presented mid-RUN and held until accepted.
        issue(8'd7, 8'd6);
        step();
        step();
        a = 8'd5; b = 8'd95; in_valid = 1'b1;
        wait_out();
        chk("t4_first_sum",  32'(sum),  32'd13);
        chk("t4_first_cout", 32'(cout), 32'd0);
        step();                         // DONE->IDLE, no accept here
        chk("t4_idle_not_accepted", 32'(in_ready), 32'd1);
        step();                         // accept
        in_valid = 1'b0;
        chk("t4_second_accepted", 32'(in_ready), 32'd0);
        wait_out();
        chk("t4_second_sum",  32'(sum),  32'd100);
        chk("t4_second_cout", 32'(cout), 32'd0);
        step();

        // 5: asynchronous reset mid-RUN discards the operation.
        issue(8'd200, 8'd100);
        step();
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_out_valid", 32'(out_valid), 32'd0);
        chk("t5_rst_in_ready",  32'(in_ready),  32'd1);
        chk("t5_rst_sum",       32'(sum),       32'd0);
        chk("t5_rst_cout",      32'(cout),      32'd0);
        sb.delete();
        base = n_out;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 12; i++) step();
        chk("t5_no_output", 32'(n_out - base), 32'd0);
        issue(8'd5, 8'd95);
        wait_out();
        chk("t5_after_sum",  32'(sum),  32'd100);
        chk("t5_after_cout", 32'(cout), 32'd0);
        step();

        // 6: random pairs with random output stalls.
        base = n_out;
        fork
            begin
                for (int i = 0; i < 100; i++) begin
                    logic [W-1:0] ra;
                    logic [W-1:0] rb;
                    ra = W'($urandom_range(0, 255));
                    rb = W'($urandom_range(0, 255));
                    issue(ra, rb);
                end
            end
            begin
                int n;
                n = 0;
                while ((n_out - base) < 100 && n < 20000) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    step();
                    n++;
                end
                out_ready = 1'b1;
            end
        join
        for (int i = 0; i < 30 && sb.size() != 0; i++) step();
        chk("t6_count",    32'(n_out - base), 32'd100);
        chk("t6_sb_empty", 32'(sb.size()),    32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
